// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with load, one-shot mode, wrap/done flags and Gray copy.
// Latency: q, wrap, done update one edge after inputs are sampled; no backpressure (always accepts).
module modn_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("modn_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             done_nxt;

  assign tc     = up_dn ? (q == MAXV) : (q == '0);
  assign q_gray = q ^ (q >> 1);

  // Terminal step either wraps (pulse wrap) or, in one-shot mode, parks q and sets done.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    done_nxt = done;
    if (load) begin
      q_nxt    = (d > MAXV) ? MAXV : d;
      done_nxt = 1'b0;
    end else if (en && !done) begin
      if (tc) begin
        if (one_shot) begin
          done_nxt = 1'b1;
        end else begin
          q_nxt    = up_dn ? '0 : MAXV;
          wrap_nxt = 1'b1;
        end
      end else begin
        q_nxt = up_dn ? (q + ONE) : (q - ONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter: three configurations share stimulus; each step
// queues its expected outputs and compares them at the following falling edge.
module tb_modn_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, one_shot;
  logic [3:0] d;

  logic [3:0] q16, g16, q10, g10;
  logic [2:0] q8, g8;
  logic       t16, w16, d16, t10, w10, d10, t8, w8, d8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         sel;
    logic [3:0] q;
    logic       wrap;
    logic       done;
    logic       tc;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d), .one_shot(one_shot),
    .q(q16), .q_gray(g16), .tc(t16), .wrap(w16), .done(d16));

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d), .one_shot(one_shot),
    .q(q10), .q_gray(g10), .tc(t10), .wrap(w10), .done(d10));

  modn_updown_counter #(.WIDTH(3), .MODULUS(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d[2:0]), .one_shot(one_shot),
    .q(q8), .q_gray(g8), .tc(t8), .wrap(w8), .done(d8));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] dd, input logic os);
    rst = r; en = e; up_dn = u; load = l; d = dd; one_shot = os;
  endtask

  task automatic check_out();
    exp_t       e;
    logic [3:0] oq, og, eg;
    logic       ow, od, ot;
    e  = sb.pop_front();
    oq = '0; og = '0; ow = 1'b0; od = 1'b0; ot = 1'b0;
    case (e.sel)
      0: begin oq = q16; og = g16; ow = w16; od = d16; ot = t16; end
      1: begin oq = q10; og = g10; ow = w10; od = d10; ot = t10; end
      default: begin oq = {1'b0, q8}; og = {1'b0, g8}; ow = w8; od = d8; ot = t8; end
    endcase
    eg = e.q ^ (e.q >> 1);
    chk({e.tag, ".q"},    oq, e.q);
    chk({e.tag, ".gray"}, og, eg);
    chk({e.tag, ".wrap"}, {3'b0, ow}, {3'b0, e.wrap});
    chk({e.tag, ".done"}, {3'b0, od}, {3'b0, e.done});
    chk({e.tag, ".tc"},   {3'b0, ot}, {3'b0, e.tc});
    chk({e.tag, ".x"},    {3'b0, $isunknown({oq, og, ow, od, ot})}, 4'b0);
  endtask

  // One clock step: queue the expectation, let the edge happen, compare mid-cycle.
  task automatic cyc(input int sel, input logic [3:0] eq, input logic ew, input logic ed,
                     input logic et, input string tag);
    exp_t e;
    e.sel = sel; e.q = eq; e.wrap = ew; e.done = ed; e.tc = et; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    set(0, 0, 1, 0, 4'd0, 0);
    @(negedge clk);
    cyc(0, 4'd0, 0, 0, 0, "rst_a");
    cyc(0, 4'd0, 0, 0, 0, "rst_b");

    // Mod-16 up count in wrap mode
    set(1, 1, 1, 0, 4'd0, 0);
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] eq;
      eq = 4'(k % 16);
      cyc(0, eq, eq == 4'd0, 0, eq == 4'd15, $sformatf("up16_%0d", k));
      if (eq == 4'd15) chk("gray15", g16, 4'b1000);
    end

    // Mod-10 down count with wrap, then load clamp
    set(1, 0, 0, 1, 4'd3, 0);
    cyc(1, 4'd3, 0, 0, 0, "ld3");
    set(1, 1, 0, 0, 4'd0, 0);
    cyc(1, 4'd2, 0, 0, 0, "dn2");
    cyc(1, 4'd1, 0, 0, 0, "dn1");
    cyc(1, 4'd0, 0, 0, 1, "dn0");
    cyc(1, 4'd9, 1, 0, 0, "dn9");
    cyc(1, 4'd8, 0, 0, 0, "dn8");
    set(1, 0, 0, 1, 4'd12, 0);
    cyc(1, 4'd9, 0, 0, 0, "clamp");

    // One-shot up from 7
    set(1, 0, 1, 1, 4'd7, 1);
    cyc(1, 4'd7, 0, 0, 0, "os_ld7");
    set(1, 1, 1, 0, 4'd0, 1);
    cyc(1, 4'd8, 0, 0, 0, "os8");
    cyc(1, 4'd9, 0, 0, 1, "os9");
    cyc(1, 4'd9, 0, 1, 1, "os_done");
    cyc(1, 4'd9, 0, 1, 1, "os_hold1");
    cyc(1, 4'd9, 0, 1, 1, "os_hold2");
    set(1, 0, 1, 1, 4'd0, 1);
    cyc(1, 4'd0, 0, 0, 0, "os_ld0");
    set(1, 1, 1, 0, 4'd0, 1);
    cyc(1, 4'd1, 0, 0, 0, "os_resume");

    // Direction reversal, enable drop, load beats enable
    set(1, 0, 1, 1, 4'd3, 0);
    cyc(1, 4'd3, 0, 0, 0, "dir_ld3");
    set(1, 1, 1, 0, 4'd0, 0);
    cyc(1, 4'd4, 0, 0, 0, "dir_up4");
    cyc(1, 4'd5, 0, 0, 0, "dir_up5");
    set(1, 1, 0, 0, 4'd0, 0);
    cyc(1, 4'd4, 0, 0, 0, "dir_dn4");
    cyc(1, 4'd3, 0, 0, 0, "dir_dn3");
    set(1, 0, 0, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 4'd3, 0, 0, 0, $sformatf("hold_%0d", k));
    set(1, 1, 0, 1, 4'd6, 0);
    cyc(1, 4'd6, 0, 0, 0, "ld_wins");

    // tc follows up_dn with no clock edge
    set(1, 0, 0, 1, 4'd0, 0);
    cyc(1, 4'd0, 0, 0, 1, "tc_ld0");
    up_dn = 1'b1;
    #1;
    chk("tc_comb_up", {3'b0, t10}, 4'd0);
    up_dn = 1'b0;
    #1;
    chk("tc_comb_dn", {3'b0, t10}, 4'd1);

    // Mode switches at terminal, done sticky, reset clears done
    set(1, 0, 1, 1, 4'd8, 0);
    cyc(1, 4'd8, 0, 0, 0, "ms_ld8");
    set(1, 1, 1, 0, 4'd0, 0);
    cyc(1, 4'd9, 0, 0, 1, "ms_9");
    set(1, 1, 1, 0, 4'd0, 1);
    cyc(1, 4'd9, 0, 1, 1, "ms_to_os");
    set(1, 1, 1, 0, 4'd0, 0);
    cyc(1, 4'd9, 0, 1, 1, "ms_sticky");
    set(0, 1, 1, 0, 4'd0, 0);
    cyc(1, 4'd0, 0, 0, 0, "ms_rst");

    // Reset mid-count overrides load and enable
    set(1, 0, 1, 1, 4'd6, 0);
    cyc(1, 4'd6, 0, 0, 0, "rs_ld6");
    set(1, 1, 1, 0, 4'd0, 0);
    cyc(1, 4'd7, 0, 0, 0, "rs_7");
    set(0, 1, 1, 1, 4'd2, 0);
    for (int k = 0; k < 3; k++) cyc(1, 4'd0, 0, 0, 0, $sformatf("rs_hold_%0d", k));
    set(1, 1, 1, 0, 4'd0, 0);
    cyc(1, 4'd1, 0, 0, 0, "rs_resume");

    // Full-range modulus, down from reset
    set(0, 0, 0, 0, 4'd0, 0);
    cyc(2, 4'd0, 0, 0, 1, "m8_rst");
    set(1, 1, 0, 0, 4'd0, 0);
    cyc(2, 4'd7, 1, 0, 0, "m8_7");
    cyc(2, 4'd6, 0, 0, 0, "m8_6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
